// File: rtl/chk_report_arb.sv
// chk_report_arb: round-robin arbiter that funnels checker reports from NCHK
// bound checkers onto one valid/ready report channel. It tracks which checkers
// have reported and flags completion (all_done) or a timeout.
module chk_report_arb #(
    parameter int NCHK    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCHK-1:0]         req,
    input  logic [NCHK*DW-1:0]      req_data,
    output logic [NCHK-1:0]         gnt,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [$clog2(NCHK)-1:0] rpt_id,
    output logic [DW-1:0]           rpt_data,
    output logic                    rpt_dup,
    output logic                    all_done,
    output logic                    timeout
);

    localparam int IW = $clog2(NCHK);
    // A zero TIMEOUT disables the counter, but it still needs one bit to exist.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        TMO  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NCHK-1:0]   seen;
    logic [NCHK-1:0]   seen_nxt;
    logic [NCHK-1:0]   win_mask;
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     win;
    logic              win_found;
    logic [DW-1:0]     win_data;
    logic              slot_free;
    logic              grant_en;
    logic              valid_nxt;
    logic              done_cond;
    logic              tmo_hit;
    int                idx;

    // Winner search: first requester found scanning upward from ptr, wrapping.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < NCHK; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCHK) begin
                idx = idx - NCHK;
            end
            if (!win_found && req[IW'(idx)]) begin
                win       = IW'(idx);
                win_found = 1'b1;
            end
        end
    end

    // Payload mux selecting the winner's data word.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < NCHK; i++) begin
            if (win == IW'(i)) begin
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    // Grant decision and look-ahead of the slot/seen state after this edge.
    always_comb begin
        slot_free = !rpt_valid || rpt_ready;
        grant_en  = (state != TMO) && slot_free && win_found;
        win_mask  = NCHK'(1) << win;
        gnt       = (grant_en && !rst) ? win_mask : '0;
        seen_nxt  = grant_en ? (seen | win_mask) : seen;
        valid_nxt = grant_en || (rpt_valid && !rpt_ready);
        done_cond = (&seen_nxt) && !valid_nxt;
        tmo_hit   = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    end

    // Next-state logic; completion beats timeout when both land together.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (done_cond) begin
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    state_nxt = TMO;
                end
            end
            DONE:    state_nxt = DONE;
            TMO:     state_nxt = TMO;
            default: state_nxt = RUN;
        endcase
    end

    // Status outputs follow the sticky terminal states directly.
    always_comb begin
        all_done = (state == DONE);
        timeout  = (state == TMO);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout counter runs only while waiting for completion and saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == RUN && TIMEOUT != 0 && cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Output slot, seen mask and round-robin pointer, all updated on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_valid <= 1'b0;
            rpt_id    <= '0;
            rpt_data  <= '0;
            rpt_dup   <= 1'b0;
            seen      <= '0;
            ptr       <= '0;
        end else if (grant_en) begin
            rpt_valid <= 1'b1;
            rpt_id    <= win;
            rpt_data  <= win_data;
            rpt_dup   <= seen[win];
            seen      <= seen_nxt;
            ptr       <= (win == IW'(NCHK - 1)) ? '0 : win + IW'(1);
        end else if (rpt_valid && rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chk_report_arb.sv
// tb_chk_report_arb: directed scenarios followed by random request/ready
// traffic, all compared against a cycle-level reference model of the arbiter.
module tb_chk_report_arb;

    localparam int NCHK    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 20;

    logic               clk;
    logic               rst;
    logic [NCHK-1:0]    req;
    logic [NCHK*DW-1:0] req_data;
    logic [NCHK-1:0]    gnt;
    logic               rpt_valid;
    logic               rpt_ready;
    logic [1:0]         rpt_id;
    logic [DW-1:0]      rpt_data;
    logic               rpt_dup;
    logic               all_done;
    logic               timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: the report slot, which checkers reported, whose turn
    // it is, and how the run ended.
    bit          m_valid;
    int          m_id;
    logic [31:0] m_data;
    bit          m_dup;
    bit [3:0]    m_seen;
    int          m_ptr;
    bit          m_done;
    bit          m_tmo;
    int          m_cycles;

    chk_report_arb #(.NCHK(NCHK), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_id    (rpt_id),
        .rpt_data  (rpt_data),
        .rpt_dup   (rpt_dup),
        .all_done  (all_done),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_valid  = 0;
        m_id     = 0;
        m_data   = '0;
        m_dup    = 0;
        m_seen   = '0;
        m_ptr    = 0;
        m_done   = 0;
        m_tmo    = 0;
        m_cycles = 0;
    endtask

    // Who the model expects to win this cycle, or -1 for no grant.
    function automatic int modelWinner();
        int i;
        if (m_tmo) return -1;
        if (m_valid && !rpt_ready) return -1;
        for (int k = 0; k < NCHK; k++) begin
            i = (m_ptr + k) % NCHK;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelAdvance();
        int w;
        w = modelWinner();
        if (w >= 0) begin
            m_dup     = m_seen[w];
            m_valid   = 1;
            m_id      = w;
            m_data    = req_data[w*DW +: DW];
            m_seen[w] = 1'b1;
            m_ptr     = (w + 1) % NCHK;
        end else if (m_valid && rpt_ready) begin
            m_valid = 0;
        end
        if (!m_done && !m_tmo) begin
            if ($countones(m_seen) == NCHK && !m_valid) begin
                m_done = 1;
            end else if (m_cycles == TIMEOUT - 1) begin
                m_tmo = 1;
            end
            m_cycles++;
        end
    endtask

    task automatic setData(input int i, input logic [31:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rdy);
        req       = r;
        rpt_ready = rdy;
        #3;
    endtask

    task automatic checkOutput();
        int w;
        w = modelWinner();
        check("gnt", {28'd0, gnt}, (w < 0) ? 32'd0 : (32'd1 << w));
        check("rpt_valid", {31'd0, rpt_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("rpt_id", {30'd0, rpt_id}, m_id);
            check("rpt_data", rpt_data, m_data);
            check("rpt_dup", {31'd0, rpt_dup}, {31'd0, m_dup});
        end
        check("all_done", {31'd0, all_done}, {31'd0, m_done});
        check("timeout", {31'd0, timeout}, {31'd0, m_tmo});
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
        check({tag, "_valid"}, {31'd0, rpt_valid}, 32'd0);
        check({tag, "_id"}, {30'd0, rpt_id}, 32'd0);
        check({tag, "_data"}, rpt_data, 32'd0);
        check({tag, "_dup"}, {31'd0, rpt_dup}, 32'd0);
        check({tag, "_all_done"}, {31'd0, all_done}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    task automatic endCycle();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        req       = '0;
        rpt_ready = 1'b0;
        @(posedge clk);
        #1;
        checkReset("rst");
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] pend;
        logic       rdy;
        int         w;

        rst       = 1'b1;
        req       = '0;
        rpt_ready = 1'b0;
        req_data  = '0;
        for (int i = 0; i < NCHK; i++) setData(i, 32'h12345678 + i);

        // Single pass: all four request at once, drained back to back.
        doReset();
        pend = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(pend, 1'b1);
            checkOutput();
            check("sp_gnt_order", {28'd0, gnt}, 32'd1 << k);
            endCycle();
            pend[k] = 1'b0;
        end
        applyStimulus(4'b0000, 1'b1);
        checkOutput();
        check("sp_last_id", {30'd0, rpt_id}, 32'd3);
        check("sp_last_data", rpt_data, 32'h1234567B);
        check("sp_done_early", {31'd0, all_done}, 32'd0);
        endCycle();
        applyStimulus(4'b0000, 1'b1);
        checkOutput();
        check("sp_all_done", {31'd0, all_done}, 32'd1);
        endCycle();

        // Round-robin fairness among duplicate requesters 0 and 2.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0101, 1'b1);
            checkOutput();
            check("rr_gnt", {28'd0, gnt}, (k % 2 == 0) ? 32'd1 : 32'd4);
            if (k > 0) check("rr_dup", {31'd0, rpt_dup}, 32'd1);
            check("rr_done", {31'd0, all_done}, 32'd1);
            endCycle();
        end

        // Backpressure, then timeout with checker 3 never reporting.
        doReset();
        applyStimulus(4'b0001, 1'b0);
        checkOutput();
        check("bp_first_gnt", {28'd0, gnt}, 32'd1);
        endCycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0010, 1'b0);
            checkOutput();
            check("bp_no_gnt", {28'd0, gnt}, 32'd0);
            check("bp_id_stable", {30'd0, rpt_id}, 32'd0);
            check("bp_data_stable", rpt_data, 32'h12345678);
            endCycle();
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput();
        check("bp_resume", {28'd0, gnt}, 32'd2);
        endCycle();
        applyStimulus(4'b0100, 1'b1);
        checkOutput();
        check("to_gnt2", {28'd0, gnt}, 32'd4);
        endCycle();
        for (int c = 8; c < 18; c++) begin
            applyStimulus(4'b0000, 1'b1);
            checkOutput();
            endCycle();
        end
        applyStimulus(4'b0001, 1'b0);
        checkOutput();
        check("to_dup_gnt", {28'd0, gnt}, 32'd1);
        endCycle();
        applyStimulus(4'b0010, 1'b0);
        checkOutput();
        check("to_not_yet", {31'd0, timeout}, 32'd0);
        endCycle();
        for (int c = 20; c < 22; c++) begin
            applyStimulus(4'b0010, 1'b0);
            checkOutput();
            check("to_timeout", {31'd0, timeout}, 32'd1);
            check("to_no_done", {31'd0, all_done}, 32'd0);
            check("to_no_gnt", {28'd0, gnt}, 32'd0);
            check("to_held", {31'd0, rpt_valid}, 32'd1);
            endCycle();
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput();
        check("to_drain_no_gnt", {28'd0, gnt}, 32'd0);
        endCycle();
        applyStimulus(4'b0010, 1'b1);
        checkOutput();
        check("to_drained", {31'd0, rpt_valid}, 32'd0);
        check("to_idle_gnt", {28'd0, gnt}, 32'd0);
        endCycle();

        // Reset in the middle of a pass, then a clean rerun.
        doReset();
        pend = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(pend, 1'b1);
            checkOutput();
            endCycle();
            pend[k] = 1'b0;
        end
        applyStimulus(4'b1000, 1'b1);
        rst = 1'b1;
        #1;
        checkReset("mid");
        modelReset();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        pend = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(pend, 1'b1);
            checkOutput();
            w = modelWinner();
            endCycle();
            if (w >= 0) pend[w] = 1'b0;
        end
        check("mid_rerun_done", {31'd0, all_done}, 32'd1);

        // Race: last unique report accepted as the counter reaches TIMEOUT-1.
        doReset();
        pend = 4'b0111;
        for (int c = 0; c < 22; c++) begin
            if (c == 17) pend[3] = 1'b1;
            rdy = !(c == 17 || c == 18);
            applyStimulus(pend, rdy);
            checkOutput();
            if (c == 17) check("race_gnt3", {28'd0, gnt}, 32'd8);
            if (c == 19) check("race_pre_done", {31'd0, all_done}, 32'd0);
            if (c >= 20) begin
                check("race_done", {31'd0, all_done}, 32'd1);
                check("race_no_tmo", {31'd0, timeout}, 32'd0);
            end
            w = modelWinner();
            endCycle();
            if (w >= 0) pend[w] = 1'b0;
        end

        // Random traffic episodes against the model.
        for (int ep = 0; ep < 8; ep++) begin
            doReset();
            pend = '0;
            for (int c = 0; c < 30; c++) begin
                for (int i = 0; i < NCHK; i++) begin
                    if (!pend[i] && $urandom_range(0, 3) == 0) begin
                        pend[i] = 1'b1;
                        setData(i, $urandom);
                    end
                end
                rdy = ($urandom_range(0, 3) != 0);
                applyStimulus(pend, rdy);
                checkOutput();
                w = modelWinner();
                endCycle();
                if (w >= 0) pend[w] = ($urandom_range(0, 4) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
